// File: rtl/mac_vec_array_if.sv
// Bus bundle for mac_vec_array: vector-pair input, block-read handshake,
// external 2-port memory write/read ports and the streamed result output.
//   master : environment side (drives vector pairs, block-read requests,
//            memory read data)
//   slave  : mac_vec_array side
// Handshake rule for both EN_mac/RDY_mac and EN_blockRead/RDY_blockRead:
// a request transfers on a posedge where EN and RDY are both 1. RDY is a
// registered output and never depends on EN in the same cycle. A request
// made while RDY is 0 is dropped, not held.
// Strobes EN_writeMem, EN_readMem and VALID_memVal are single-cycle
// qualifiers for their address/data buses.
interface mac_vec_array_if #(
    parameter int LANES  = 4,
    parameter int IN_W   = 16,
    parameter int ACC_W  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                  EN_mac;
    logic [LANES*IN_W-1:0] mac_vectA;
    logic [LANES*IN_W-1:0] mac_vectB;
    logic                  mac_acc;
    logic                  mac_sat;
    logic                  RDY_mac;
    logic                  EN_blockRead;
    logic                  RDY_blockRead;
    logic                  EN_writeMem;
    logic [ADDR_W-1:0]     writeMem_addr;
    logic [ACC_W-1:0]      writeMem_val;
    logic                  EN_readMem;
    logic [ADDR_W-1:0]     readMem_addr;
    logic [ACC_W-1:0]      readMem_val;
    logic                  VALID_memVal;
    logic [ACC_W-1:0]      memVal_data;
    logic [1:0]            dbg_state;   // FSM state, for debug and checkers

    modport master (
        output EN_mac, mac_vectA, mac_vectB, mac_acc, mac_sat,
        output EN_blockRead, readMem_val,
        input  RDY_mac, RDY_blockRead, EN_writeMem, writeMem_addr, writeMem_val,
        input  EN_readMem, readMem_addr, VALID_memVal, memVal_data, dbg_state
    );

    modport slave (
        input  EN_mac, mac_vectA, mac_vectB, mac_acc, mac_sat,
        input  EN_blockRead, readMem_val,
        output RDY_mac, RDY_blockRead, EN_writeMem, writeMem_addr, writeMem_val,
        output EN_readMem, readMem_addr, VALID_memVal, memVal_data, dbg_state
    );
endinterface

// File: rtl/mac_vec_array.sv
// mac_vec_array: LANES-wide unsigned dot-product MAC. Each accepted vector
// pair produces one ACC_W result (optionally accumulated onto the previous
// result of the block, optionally saturated) written in order to addresses
// 0..DEPTH-1 of an external 2-port memory. A full block is streamed back on
// request as a contiguous DEPTH-beat VALID burst, then the next block fills.
// Ports:
//   CLK  - clock, all logic on posedge
//   RST  - synchronous reset, active-high
//   bus  - mac_vec_array_if.slave (vector input, block read, memory ports,
//          streamed output, debug state)
module mac_vec_array #(
    parameter int LANES   = 4,
    parameter int IN_W    = 16,
    parameter int ACC_W   = 32,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MEM_LAT = 1
) (
    input  logic           CLK,
    input  logic           RST,
    mac_vec_array_if.slave bus
);
    localparam int PROD_W = 2 * IN_W;
    localparam int DOT_W  = PROD_W + $clog2(LANES);
    // One spare bit above the wider of dot/acc so dot + acc never loses its
    // carry before the saturation test.
    localparam int SUM_W  = ((DOT_W > ACC_W) ? DOT_W : ACC_W) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t              state;
    logic                rdy_mac;
    logic                rdy_block_read;
    logic [ADDR_W-1:0]   fill_idx;

    logic                s1_valid;
    logic                s1_acc;
    logic                s1_sat;
    logic [ADDR_W-1:0]   s1_addr;
    logic [PROD_W-1:0]   s1_prod [LANES];

    logic [ACC_W-1:0]    acc_reg;
    logic                en_write_mem;
    logic [ADDR_W-1:0]   write_addr;
    logic [ACC_W-1:0]    write_val;

    logic                en_read_mem;
    logic [ADDR_W-1:0]   read_addr;
    logic [MEM_LAT-1:0]  rd_pipe;     // tracks reads in flight in the memory
    logic [ADDR_W-1:0]   beat_idx;
    logic                valid_mem_val;
    logic [ACC_W-1:0]    mem_val_data;

    logic [SUM_W-1:0]    sum;
    logic [ACC_W-1:0]    result;
    logic                accept_mac;
    logic                accept_read;

    assign accept_mac  = bus.EN_mac && rdy_mac;
    assign accept_read = bus.EN_blockRead && rdy_block_read;

    // Stage 2 arithmetic: add-tree over the registered products plus the
    // optional running accumulator, then clamp or wrap to ACC_W.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + SUM_W'(s1_prod[i]);
        end
        if (s1_acc) begin
            sum = sum + SUM_W'(acc_reg);
        end
        result = sum[ACC_W-1:0];
        if (s1_sat && (|sum[SUM_W-1:ACC_W])) begin
            result = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= FILL;
            rdy_mac        <= 1'b0;
            rdy_block_read <= 1'b0;
            fill_idx       <= '0;
            s1_valid       <= 1'b0;
            s1_acc         <= 1'b0;
            s1_sat         <= 1'b0;
            s1_addr        <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod[i] <= '0;
            end
            acc_reg        <= '0;
            en_write_mem   <= 1'b0;
            write_addr     <= '0;
            write_val      <= '0;
            en_read_mem    <= 1'b0;
            read_addr      <= '0;
            rd_pipe        <= '0;
            beat_idx       <= '0;
            valid_mem_val  <= 1'b0;
            mem_val_data   <= '0;
        end else begin
            // Stage 1: register per-lane products and the per-pair modes.
            s1_valid <= accept_mac;
            if (accept_mac) begin
                for (int i = 0; i < LANES; i++) begin
                    s1_prod[i] <= PROD_W'(bus.mac_vectA[i*IN_W +: IN_W])
                                * PROD_W'(bus.mac_vectB[i*IN_W +: IN_W]);
                end
                s1_acc  <= bus.mac_acc;
                s1_sat  <= bus.mac_sat;
                s1_addr <= fill_idx;
            end

            // Stage 2: issue the write; the accumulator follows the written value.
            en_write_mem <= s1_valid;
            if (s1_valid) begin
                write_addr <= s1_addr;
                write_val  <= result;
                acc_reg    <= result;
            end

            // Read return path: memory data is registered once more.
            rd_pipe       <= MEM_LAT'({rd_pipe, en_read_mem});
            valid_mem_val <= rd_pipe[MEM_LAT-1];
            mem_val_data  <= rd_pipe[MEM_LAT-1] ? bus.readMem_val : '0;

            case (state)
                FILL: begin
                    rdy_mac <= 1'b1;
                    if (accept_mac) begin
                        fill_idx <= fill_idx + ADDR_W'(1);
                        if (fill_idx == LAST) begin
                            rdy_mac <= 1'b0;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means the last write is on the bus now.
                    if (!s1_valid) begin
                        state          <= READY;
                        rdy_block_read <= 1'b1;
                    end
                end
                READY: begin
                    if (accept_read) begin
                        state          <= READ;
                        rdy_block_read <= 1'b0;
                        en_read_mem    <= 1'b1;
                        read_addr      <= '0;
                        beat_idx       <= '0;
                    end
                end
                READ: begin
                    if (en_read_mem) begin
                        if (read_addr == LAST) begin
                            en_read_mem <= 1'b0;
                        end else begin
                            read_addr <= read_addr + ADDR_W'(1);
                        end
                    end
                    if (valid_mem_val) begin
                        beat_idx <= beat_idx + ADDR_W'(1);
                        if (beat_idx == LAST) begin
                            state    <= FILL;
                            fill_idx <= '0;
                            acc_reg  <= '0;
                            rdy_mac  <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.RDY_mac       = rdy_mac;
    assign bus.RDY_blockRead = rdy_block_read;
    assign bus.EN_writeMem   = en_write_mem;
    assign bus.writeMem_addr = write_addr;
    assign bus.writeMem_val  = write_val;
    assign bus.EN_readMem    = en_read_mem;
    assign bus.readMem_addr  = read_addr;
    assign bus.VALID_memVal  = valid_mem_val;
    assign bus.memVal_data   = mem_val_data;
    assign bus.dbg_state     = state;
endmodule

// File: tb/tb_mac_vec_array.sv
// Testbench for mac_vec_array: behavioural memory, write monitor, a
// plain-arithmetic reference model feeding an expected queue, and one task
// per scenario.
module tb_mac_vec_array;
    localparam int LANES   = 4;
    localparam int IN_W    = 16;
    localparam int ACC_W   = 32;
    localparam int DEPTH   = 64;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int MEM_LAT = 1;
    localparam int VW      = LANES * IN_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mac_vec_array_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    mac_vec_array #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // ---------------- external memory + write monitor ----------------
    logic [ACC_W-1:0]  mem [DEPTH];
    logic [ACC_W-1:0]  rd_q = '0;
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [ACC_W-1:0]  wr_val_q[$];
    int                wr_cyc_q[$];
    int                both_cnt = 0;

    assign bus.readMem_val = rd_q;

    always @(posedge clk) begin
        if (bus.EN_writeMem === 1'b1) begin
            mem[bus.writeMem_addr] <= bus.writeMem_val;
            wr_addr_q.push_back(bus.writeMem_addr);
            wr_val_q.push_back(bus.writeMem_val);
            wr_cyc_q.push_back(cyc + 1);
        end
        if (bus.EN_readMem === 1'b1) rd_q <= mem[bus.readMem_addr];
        if (bus.EN_writeMem === 1'b1 && bus.EN_readMem === 1'b1) both_cnt++;
        cyc++;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [ACC_W-1:0] exp_q[$];
    int               acc_cyc_q[$];
    int               model_cnt = 0;
    logic [ACC_W-1:0] model_acc = '0;

    function automatic logic [ACC_W-1:0] ref_result(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                                    input bit acc, input bit sat,
                                                    input logic [ACC_W-1:0] prev);
        logic [63:0] total;
        logic [63:0] limit;
        total = '0;
        limit = (64'd1 << ACC_W) - 64'd1;
        for (int i = 0; i < LANES; i++) total = total + 64'(a[i*IN_W +: IN_W]) * 64'(b[i*IN_W +: IN_W]);
        if (acc) total = total + 64'(prev);
        if (sat && total > limit) return limit[ACC_W-1:0];
        return total[ACC_W-1:0];
    endfunction

    function automatic logic [VW-1:0] splat(input logic [IN_W-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'($urandom);
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_block();
        exp_q.delete();
        acc_cyc_q.delete();
        wr_addr_q.delete();
        wr_val_q.delete();
        wr_cyc_q.delete();
        model_cnt = 0;
        model_acc = '0;
    endtask

    // Offer one pair; a block accepts exactly DEPTH pairs.
    task automatic drive_pair(input logic [VW-1:0] a, input logic [VW-1:0] b, input bit acc, input bit sat);
        logic [ACC_W-1:0] r;
        @(negedge clk);
        bus.EN_mac       = 1'b1;
        bus.mac_vectA    = a;
        bus.mac_vectB    = b;
        bus.mac_acc      = acc;
        bus.mac_sat      = sat;
        bus.EN_blockRead = 1'b0;
        if (model_cnt < DEPTH) begin
            r = ref_result(a, b, acc, sat, model_acc);
            exp_q.push_back(r);
            acc_cyc_q.push_back(cyc + 1);
            model_acc = r;
            model_cnt++;
        end
    endtask

    task automatic fill_const(input logic [IN_W-1:0] av, input logic [IN_W-1:0] bv, input bit acc, input bit sat);
        clear_block();
        for (int i = 0; i < DEPTH; i++) drive_pair(splat(av), splat(bv), acc, sat);
        @(negedge clk);
        bus.EN_mac = 1'b0;
    endtask

    logic [ACC_W-1:0] got_q[$];
    bit               rb_timeout;
    logic             rb_rdy_next;
    int               rb_first_re;
    int               rb_first_v;
    int               rb_last_v;

    task automatic read_block();
        int guard;
        got_q.delete();
        rb_timeout  = 1'b0;
        rb_rdy_next = 1'b0;
        rb_first_re = -1;
        rb_first_v  = -1;
        rb_last_v   = -1;
        @(negedge clk);
        bus.EN_mac       = 1'b0;
        bus.EN_blockRead = 1'b0;
        guard = 0;
        while (bus.RDY_blockRead !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.RDY_blockRead !== 1'b1) begin
            rb_timeout = 1'b1;
            return;
        end
        bus.EN_blockRead = 1'b1;
        @(negedge clk);
        bus.EN_blockRead = 1'b0;
        guard = 0;
        while (got_q.size() < DEPTH && guard < DEPTH + 20) begin
            if (bus.EN_readMem === 1'b1 && rb_first_re < 0) rb_first_re = cyc;
            if (bus.VALID_memVal === 1'b1) begin
                if (rb_first_v < 0) rb_first_v = cyc;
                rb_last_v = cyc;
                got_q.push_back(bus.memVal_data);
            end
            @(negedge clk);
            guard++;
        end
        rb_timeout  = (got_q.size() < DEPTH);
        rb_rdy_next = bus.RDY_mac;
        model_cnt   = 0;
        model_acc   = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.RDY_mac, bus.RDY_blockRead, bus.EN_writeMem, bus.writeMem_addr, bus.writeMem_val,
             bus.EN_readMem, bus.readMem_addr, bus.VALID_memVal, bus.memVal_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b rdyb=%b we=%b wa=%h wv=%h re=%b ra=%h v=%b d=%h required all 0",
                     bus.RDY_mac, bus.RDY_blockRead, bus.EN_writeMem, bus.writeMem_addr, bus.writeMem_val,
                     bus.EN_readMem, bus.readMem_addr, bus.VALID_memVal, bus.memVal_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.RDY_mac !== 1'b1 || bus.RDY_blockRead !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: RDY_mac=%b RDY_blockRead=%b required 1/0", bus.RDY_mac, bus.RDY_blockRead);
        end
    endtask

    task automatic test_wrap_fill();
        clear_block();
        for (int i = 0; i < DEPTH; i++) drive_pair(splat(IN_W'(i)), splat(IN_W'(2 * i)), 1'b0, 1'b0);
        @(negedge clk);
        bus.EN_mac = 1'b0;
        n_vec++;
        if (bus.RDY_mac !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_rdy_drop: RDY_mac=%b required 0", bus.RDY_mac);
        end
        read_block();
        n_vec++;
        if (wr_addr_q.size() != DEPTH) begin
            n_err++;
            $display("FAIL wrap_write_count: %0d writes, required %0d", wr_addr_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (wr_addr_q[i] !== ADDR_W'(i) || wr_val_q[i] !== ACC_W'(8 * i * i) || wr_cyc_q[i] - acc_cyc_q[i] != 2) begin
                n_err++;
                $display("FAIL wrap_write[%0d]: addr=%0d val=%0d lat=%0d required addr=%0d val=%0d lat=2",
                         i, wr_addr_q[i], wr_val_q[i], wr_cyc_q[i] - acc_cyc_q[i], i, 8 * i * i);
            end
        end
        n_vec++;
        if (rb_timeout || rb_first_v - rb_first_re != MEM_LAT + 1 || rb_last_v - rb_first_v != DEPTH - 1) begin
            n_err++;
            $display("FAIL wrap_burst: timeout=%0d lat=%0d span=%0d required 0/%0d/%0d",
                     rb_timeout, rb_first_v - rb_first_re, rb_last_v - rb_first_v, MEM_LAT + 1, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i] || got_q[i] !== ACC_W'(8 * i * i)) begin
                n_err++;
                $display("FAIL wrap_read[%0d]: got %0d required %0d", i, got_q[i], 8 * i * i);
            end
        end
        n_vec++;
        if (rb_rdy_next !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_rdy_return: RDY_mac=%b required 1", rb_rdy_next);
        end
    endtask

    task automatic test_saturation();
        logic [ACC_W-1:0] want [2];
        want[0] = 32'hFFFF_FFFF;
        want[1] = 32'hFFF8_0004;
        for (int pass = 0; pass < 2; pass++) begin
            fill_const(16'hFFFF, 16'hFFFF, 1'b0, (pass == 0));
            read_block();
            n_vec++;
            if (rb_timeout || got_q.size() != DEPTH) begin
                n_err++;
                $display("FAIL sat_burst[%0d]: timeout=%0d beats=%0d required 0/%0d", pass, rb_timeout, got_q.size(), DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i] || got_q[i] !== want[pass]) begin
                    n_err++;
                    $display("FAIL sat_read[%0d][%0d]: got %h required %h", pass, i, got_q[i], want[pass]);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        for (int blk = 0; blk < 2; blk++) begin
            fill_const(16'd1, 16'd1, 1'b1, 1'b0);
            read_block();
            n_vec++;
            if (rb_timeout || got_q.size() != DEPTH || got_q[0] !== 32'd4 || got_q[DEPTH-1] !== 32'd256) begin
                n_err++;
                $display("FAIL acc_ends[%0d]: beats=%0d first=%0d last=%0d required %0d/4/256",
                         blk, got_q.size(), got_q[0], got_q[DEPTH-1], DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL acc_read[%0d][%0d]: got %0d required %0d", blk, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        clear_block();
        for (int k = 0; k < 140; k++) begin
            if (k % 2 == 0) begin
                drive_pair(rand_vec(), rand_vec(), 1'b0, 1'b0);
            end else begin
                @(negedge clk);
                bus.EN_mac       = 1'b0;
                bus.EN_blockRead = (model_cnt < DEPTH);
                if (model_cnt < DEPTH) begin
                    n_vec++;
                    if (bus.RDY_blockRead !== 1'b0 || bus.EN_readMem !== 1'b0) begin
                        n_err++;
                        $display("FAIL gaps_fill_read: RDY_blockRead=%b EN_readMem=%b required 0/0",
                                 bus.RDY_blockRead, bus.EN_readMem);
                    end
                end
            end
        end
        read_block();
        n_vec++;
        if (wr_addr_q.size() != DEPTH) begin
            n_err++;
            $display("FAIL gaps_write_count: %0d writes, required %0d", wr_addr_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (wr_addr_q[i] !== ADDR_W'(i) || got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL gaps[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wr_addr_q[i], got_q[i], i, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 2; blk++) begin
            clear_block();
            while (model_cnt < DEPTH) begin
                drive_pair(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bus.EN_mac = 1'b0;
                end
            end
            read_block();
            n_vec++;
            if (rb_timeout || got_q.size() != DEPTH || rb_last_v - rb_first_v != DEPTH - 1) begin
                n_err++;
                $display("FAIL rand_burst[%0d]: timeout=%0d beats=%0d span=%0d", blk, rb_timeout, got_q.size(), rb_last_v - rb_first_v);
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_read[%0d][%0d]: got %h required %h", blk, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int guard;
        int beats;
        clear_block();
        for (int i = 0; i < DEPTH; i++) drive_pair(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        bus.EN_mac = 1'b0;
        guard = 0;
        while (bus.RDY_blockRead !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.EN_blockRead = 1'b1;
        @(negedge clk);
        bus.EN_blockRead = 1'b0;
        beats = 0;
        guard = 0;
        while (beats < 10 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus.VALID_memVal === 1'b1) beats++;
        end
        n_vec++;
        if (beats != 10) begin
            n_err++;
            $display("FAIL midread_beats: saw %0d beats, required 10", beats);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.VALID_memVal !== 1'b0 || bus.EN_readMem !== 1'b0 || bus.RDY_blockRead !== 1'b0) begin
            n_err++;
            $display("FAIL midread_reset: VALID=%b EN_readMem=%b RDY_blockRead=%b required 0/0/0",
                     bus.VALID_memVal, bus.EN_readMem, bus.RDY_blockRead);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.RDY_mac !== 1'b1 || bus.VALID_memVal !== 1'b0) begin
            n_err++;
            $display("FAIL midread_release: RDY_mac=%b VALID=%b required 1/0", bus.RDY_mac, bus.VALID_memVal);
        end
        clear_block();
        for (int i = 0; i < DEPTH; i++) drive_pair(rand_vec(), rand_vec(), 1'b0, 1'b1);
        read_block();
        n_vec++;
        if (rb_timeout || got_q.size() != DEPTH) begin
            n_err++;
            $display("FAIL midread_refill_burst: timeout=%0d beats=%0d required 0/%0d", rb_timeout, got_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midread_refill[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_no_overlap();
        n_vec++;
        if (both_cnt != 0) begin
            n_err++;
            $display("FAIL rw_overlap: %0d cycles with read and write together, required 0", both_cnt);
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        bus.EN_mac       = 1'b0;
        bus.mac_vectA    = '0;
        bus.mac_vectB    = '0;
        bus.mac_acc      = 1'b0;
        bus.mac_sat      = 1'b0;
        bus.EN_blockRead = 1'b0;
        test_reset();
        test_wrap_fill();
        test_saturation();
        test_accumulate();
        test_gaps();
        test_random();
        test_reset_mid_read();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
